fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch initiator for the Tomasulo core; it is the requesting end of the combinational instruction-memory read port.
- Holds the PC and drives a word address to instruction memory every cycle. It captures the returned instruction, tagged with its PC, into an in-order fetch queue.
- Dispatch drains the queue with a valid/ready handshake. Branch or jump resolution redirects the PC and flushes the queue.

Parameters:
- QUEUE_DEPTH, 4, fetch queue entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h00000000, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_en  input  1  1 = fetch allowed; 0 = hold PC and do not enqueue (halt/debug)
- imem_addr  output  32  byte address to instruction memory, equal to the PC register
- imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle
- redirect_valid  input  1  1-cycle pulse: branch/jump resolved, redirect fetch
- redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0
- deq_valid  output  1  head entry available to dispatch
- deq_ready  input  1  dispatch accepts the head entry
- deq_instr  output  32  head instruction
- deq_pc  output  32  PC of head instruction
- queue_count  output  $clog2(QUEUE_DEPTH+1)  occupied entries

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; head, tail and count = 0.
  - All queue entries = instr 32'h00000013 (NOP), pc 0.
  - deq_valid = 0, deq_instr = 32'h00000013, deq_pc = 0, queue_count = 0.
- Reset deassertion is synchronous to clk. The first fetch occurs in the first cycle after rst_n rises.
- imem_addr = pc at all times (combinational from register).
- Dequeue fire: deq_fire = deq_valid & deq_ready.
- Enqueue fire: enq_fire = fetch_en & !redirect_valid & (count < QUEUE_DEPTH | deq_fire).
  - A full queue accepts a new entry in the same cycle the head is dequeued.
- On enq_fire: entry[tail] = {imem_instr, pc}, tail = tail+1 mod QUEUE_DEPTH, pc = pc+4.
  - The PC wraps 32'hFFFFFFFC -> 0 with no error.
- Fetch-to-dispatch latency: an instruction fetched in cycle N is visible on deq_* in cycle N+1 at the earliest.
- deq_valid = (count != 0) & !redirect_valid.
  - deq_instr and deq_pc are driven from entry[head].
  - When the queue is empty, deq_instr and deq_pc hold the last head-slot contents; consumers must qualify them with deq_valid.
- On deq_fire: head = head+1 mod QUEUE_DEPTH.
- count next = count + enq_fire - deq_fire; it never exceeds QUEUE_DEPTH and never underflows.
- Redirect (redirect_valid = 1) has highest priority:
  - pc = {redirect_pc[31:2], 2'b00}; head = tail = count = 0.
  - No enqueue and no dequeue in that cycle (deq_valid is masked low).
  - Fetch from the target starts the next cycle if fetch_en = 1.
- redirect_valid together with fetch_en = 0: redirect is still applied; the PC is updated and then held.
- fetch_en = 0 without redirect: PC and tail hold; dequeue continues normally.
- Reset mid-operation discards all queued entries and any pending redirect.
- Queue state is a two-state FSM:
  - EMPTY (count = 0) -> ACTIVE on enq_fire.
  - ACTIVE -> EMPTY when count reaches 0 or on redirect.
  - Full is the condition count == QUEUE_DEPTH, not a separate state.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds two outputs: stat_fetched (32, count of enq_fire cycles) and stat_stall (32, count of cycles with fetch_en=1 & !redirect_valid & !enq_fire, i.e. queue-full stalls).
- Both counters reset to 0 asynchronously on rst_n, are not cleared by redirect, and wrap at 2^32.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset RESET_PC=0, fetch_en=1, deq_ready=0, imem returns 32'h00100093 for every addr:
  - imem_addr steps 0,4,8,12, then holds at 16.
  - queue_count reaches 4; deq_valid=1, deq_pc=0.
- From full, raise deq_ready=1 for 3 cycles:
  - each cycle one dequeue and one enqueue; queue_count stays 4.
  - deq_pc sequence 0,4,8; imem_addr 16,20,24.
- With 3 entries queued, pulse redirect_valid with redirect_pc=32'h00000043:
  - that cycle deq_valid=0; next cycle queue_count=0 and imem_addr=32'h00000040.
  - first subsequent deq_pc=32'h00000040.
- fetch_en=0 with 2 entries queued and deq_ready=1:
  - two dequeues, then deq_valid=0; imem_addr unchanged throughout.
- Assert rst_n=0 mid-cycle with a full queue:
  - immediately (no clock edge) deq_valid=0, queue_count=0, imem_addr=RESET_PC.
- FETCH_STATS_EN defined: 10 cycles with fetch_en=1, deq_ready=0, QUEUE_DEPTH=4, no redirect -> stat_fetched=4, stat_stall=6.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch initiator. Holds the PC, reads instruction
// memory combinationally every cycle and queues {instr, pc} pairs in order
// for dispatch, which drains them with a valid/ready handshake. A redirect
// reloads the PC and flushes the queue.
// Optional build macro: FETCH_STATS_EN adds stat_fetched / stat_stall counters.
//
// Handshake: an entry moves to dispatch in a cycle where deq_valid and
// deq_ready are both 1 at the rising edge. deq_valid never depends on
// deq_ready. deq_instr and deq_pc are only meaningful while deq_valid is 1.
module fetch_unit #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h00000000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fetch_en,
    output logic [31:0]                        imem_addr,
    input  logic [31:0]                        imem_instr,
    input  logic                               redirect_valid,
    input  logic [31:0]                        redirect_pc,
    output logic                               deq_valid,
    input  logic                               deq_ready,
    output logic [31:0]                        deq_instr,
    output logic [31:0]                        deq_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
`ifdef FETCH_STATS_EN
    output logic [31:0]                        stat_fetched,
    output logic [31:0]                        stat_stall,
`endif
    output logic                               queue_active
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [31:0]   NOP     = 32'h00000013;

    typedef enum logic {
        Q_EMPTY  = 1'b0,
        Q_ACTIVE = 1'b1
    } q_state_e;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   entry_instr_q [QUEUE_DEPTH];
    logic [31:0]   entry_instr_d [QUEUE_DEPTH];
    logic [31:0]   entry_pc_q    [QUEUE_DEPTH];
    logic [31:0]   entry_pc_d    [QUEUE_DEPTH];
    q_state_e      state_q, state_d;
    logic          deq_fire;
    logic          enq_fire;

    // The two low redirect bits are ignored: targets are always word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Outputs read straight from registers; deq_valid is masked by a redirect.
    always_comb begin
        imem_addr    = pc_q;
        deq_valid    = (count_q != '0) & ~redirect_valid;
        deq_instr    = entry_instr_q[head_q];
        deq_pc       = entry_pc_q[head_q];
        queue_count  = count_q;
        queue_active = (state_q == Q_ACTIVE);
    end

    // Next-state: redirect flushes everything, otherwise enqueue/dequeue.
    always_comb begin
        deq_fire      = deq_valid & deq_ready;
        enq_fire      = fetch_en & ~redirect_valid & ((count_q < DEPTH_C) | deq_fire);
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        entry_instr_d = entry_instr_q;
        entry_pc_d    = entry_pc_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                entry_instr_d[tail_q] = imem_instr;
                entry_pc_d[tail_q]    = pc_q;
                tail_d                = tail_q + AW'(1);
                pc_d                  = pc_q + 32'd4;
            end
            if (deq_fire) begin
                head_d = head_q + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (redirect_valid || count_d == '0) begin
            state_d = Q_EMPTY;
        end else begin
            state_d = Q_ACTIVE;
        end
    end

    // State registers with asynchronous reset to an empty queue of NOPs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= Q_EMPTY;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entry_instr_q[i] <= NOP;
                entry_pc_q[i]    <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            state_q       <= state_d;
            entry_instr_q <= entry_instr_d;
            entry_pc_q    <= entry_pc_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Fetch and stall counters; unaffected by redirect, wrap naturally.
    always_comb begin
        stat_fetched_d = stat_fetched_q + {31'd0, enq_fire};
        stat_stall_d   = stat_stall_q + {31'd0, fetch_en & ~redirect_valid & ~enq_fire};
        stat_fetched   = stat_fetched_q;
        stat_stall     = stat_stall_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_stall_q   <= stat_stall_d;
        end
    end
`endif

endmodule
